// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl_if : request/result bundle of the serial adder
// Revision: 1.0
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder_ctrl : adds two W-bit operands one nibble per clock
// through an external 4-bit adder, LSB nibble first.  Revision: 1.0
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus,
  output logic [3:0]                  add_a,
  output logic [3:0]                  add_b,
  output logic                        add_c0,
  input  logic [3:0]                  add_s,
  input  logic                        add_c1
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     rem_a;
  logic [W-1:0]     rem_b;
  logic             accept;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // add_c0 doubles as the running carry; rem_* hold the nibbles still to feed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      rem_a       <= '0;
      rem_b       <= '0;
      add_a       <= '0;
      add_b       <= '0;
      add_c0      <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.sum_out <= '0;
      bus.cout    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (accept) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            idx      <= '0;
            add_a    <= bus.a_in[3:0];
            add_b    <= bus.b_in[3:0];
            add_c0   <= bus.cin;
            rem_a    <= bus.a_in >> 4;
            rem_b    <= bus.b_in >> 4;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          bus.sum_out[idx*4 +: 4] <= add_s;
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.cout <= add_c1;
            add_a    <= '0;
            add_b    <= '0;
            add_c0   <= 1'b0;
          end else begin
            add_a  <= rem_a[3:0];
            add_b  <= rem_b[3:0];
            add_c0 <= add_c1;
            rem_a  <= rem_a >> 4;
            rem_b  <= rem_b >> 4;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_adder_ctrl : vector table + scoreboard bench, NIBBLES=4
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_c0, add_c1;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_c0 (add_c0),
    .add_s  (add_s),
    .add_c1 (add_c1)
  );

  // Reference 4-bit adder on the add_* ports
  assign {add_c1, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 sum=0x%0h", bus.sum_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_sum", 32'(bus.sum_out), 32'(e.sum));
        chk("done_cout", 32'(bus.cout), 32'(e.cout));
      end
    end
  end

  task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic c,
                             input logic [15:0] s, input logic co);
    exp_t e;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = c;
    e.sum  = s;
    e.cout = co;
    exp_q.push_back(e);
  endtask

  // One full operation with timeline checks; inputs scrambled after accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] s, input logic co);
    @(negedge clk);
    drive_start(a, b, c, s, co);
    @(posedge clk);
    for (int i = 1; i <= NIBBLES; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = a ^ b;
        bus.cin   = ~c;
      end
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_done_low", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("hold_sum", 32'(bus.sum_out), 32'(s));
    chk("hold_cout", 32'(bus.cout), 32'(co));
    chk("idle_add_quiet", 32'({add_a, add_b, add_c0}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_sum", 32'(bus.sum_out), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    chk("reset_add", 32'({add_a, add_b, add_c0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sum, vecs[v].cout);

    // start during RUN is ignored
    run_op(16'h1357, 16'h2468, 1'b0, 16'h37BF, 1'b0);
    @(negedge clk);
    drive_start(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 16'h1111;
    bus.b_in  = 16'h2222;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("ign_done", 32'(bus.done), 32'd1);
    repeat (6) @(negedge clk);
    chk("ign_no_restart", 32'(bus.busy), 32'd0);

    // reset in the second RUN cycle
    drive_start(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sum", 32'(bus.sum_out), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    chk("arst_add", 32'({add_a, add_b, add_c0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_idle", 32'(bus.busy), 32'd0);
    run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);

    // back-to-back: start held through DONE
    @(negedge clk);
    drive_start(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 4) drive_start(16'hF00F, 16'h1FF1, 1'b0, 16'h1000, 1'b1);
    end
    @(negedge clk);
    chk("b2b_done1", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_rebusy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("b2b_busy_last", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("b2b_done2", 32'(bus.done), 32'd1);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
